// File: rtl/vu_frame_scheduler.sv
// Frame-rate scheduler between the level detector and npxl_controller.
// Collects per-frame peak level, applies peak-hold with timed decay, and hands one bar value per frame.
module vu_frame_scheduler #(
  parameter int LEDS         = 20,
  parameter int ADDR         = 8,
  parameter int FRAME_DIV    = 500000,
  parameter int DECAY_FRAMES = 4,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_level_valid,
  input  logic [ADDR-1:0] i_level,
  input  logic            i_npxl_rdy,
  output logic            o_npxl_send,
  output logic [ADDR-1:0] o_npxl_value,
  output logic            o_busy,
  output logic            o_overrun,
  output logic            o_err
);

  localparam int TW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    ACK      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [ADDR-1:0] fmax_reg, fmax_next;
  logic [ADDR-1:0] disp_reg, disp_next;
  logic [DW-1:0]   dcnt_reg, dcnt_next;
  logic [AW-1:0]   tcnt_reg, tcnt_next;
  logic            send_reg, send_next;
  logic            ovr_reg, ovr_next;
  logic            err_reg, err_next;

  logic            tick;
  logic            accept;
  logic [ADDR-1:0] level_clamped;
  logic [ADDR-1:0] fmax_base;

  assign tick          = (timer_reg == TW'(FRAME_DIV - 1));
  assign accept        = tick && (state_reg == IDLE);
  assign level_clamped = (i_level > ADDR'(LEDS)) ? ADDR'(LEDS) : i_level;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      fmax_reg  <= '0;
      disp_reg  <= '0;
      dcnt_reg  <= '0;
      tcnt_reg  <= '0;
      send_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      fmax_reg  <= fmax_next;
      disp_reg  <= disp_next;
      dcnt_reg  <= dcnt_next;
      tcnt_reg  <= tcnt_next;
      send_reg  <= send_next;
      ovr_reg   <= ovr_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = tick ? '0 : timer_reg + TW'(1);
    disp_next  = disp_reg;
    dcnt_next  = dcnt_reg;
    tcnt_next  = tcnt_reg;
    send_next  = 1'b0;
    ovr_next   = 1'b0;
    err_next   = 1'b0;

    // A sample arriving with an accepted tick lands in the freshly cleared accumulator.
    fmax_base = accept ? '0 : fmax_reg;
    fmax_next = (i_level_valid && (level_clamped > fmax_base)) ? level_clamped : fmax_base;

    // Ticks outside IDLE are dropped, never queued; frame state is left alone.
    if (tick && (state_reg != IDLE)) begin
      ovr_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (tick) begin
          if (fmax_reg >= disp_reg) begin
            disp_next = fmax_reg;
            dcnt_next = '0;
          end else if (dcnt_reg == DW'(DECAY_FRAMES - 1)) begin
            disp_next = disp_reg - ADDR'(1);
            dcnt_next = '0;
          end else begin
            dcnt_next = dcnt_reg + DW'(1);
          end
          state_next = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (i_npxl_rdy) begin
          send_next  = 1'b1;
          tcnt_next  = '0;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!i_npxl_rdy) begin
          state_next = DRAIN;
        end else if (tcnt_reg == AW'(ACK_TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tcnt_next = tcnt_reg + AW'(1);
        end
      end
      DRAIN: begin
        if (i_npxl_rdy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_npxl_send  = send_reg;
  assign o_npxl_value = disp_reg;
  assign o_busy       = (state_reg != IDLE);
  assign o_overrun    = ovr_reg;
  assign o_err        = err_reg;

endmodule
